// File: rtl/alu_issue_buffer_if.sv
// alu_issue_buffer_if: handshake bundle between fetch, the issue buffer and execute.
//   in_valid/in_ready/in_inst/in_pc : fetch -> buffer intake handshake
//   out_valid/out_ready             : buffer -> execute issue handshake
//   alu_op, class flags, operand,
//   pc_out                          : decoded head entry presented to execute
// slave modport is the buffer side; master modport is the surrounding pipeline side.
interface alu_issue_buffer_if #(
  parameter int unsigned PCW = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [8:0]     in_inst;
  logic [PCW-1:0] in_pc;
  logic           out_valid;
  logic           out_ready;
  logic [3:0]     alu_op;
  logic           alu_en;
  logic           ld;
  logic           st;
  logic           br;
  logic           movi;
  logic           halt;
  logic [4:0]     operand;
  logic [PCW-1:0] pc_out;

  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, alu_op, alu_en, ld, st, br, movi, halt, operand, pc_out
  );

  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, alu_op, alu_en, ld, st, br, movi, halt, operand, pc_out
  );
endinterface

// File: rtl/alu_issue_buffer.sv
// alu_issue_buffer: decode-and-issue stage upstream of the ALU.
// Decodes 9-bit instructions at intake, holds up to two decoded entries in a skid buffer
// and issues them to execute. A HALTED/RUN machine gates intake (Start / HALT opcode).
// Ports:
//   Clk         : clock, rising edge
//   Reset       : synchronous active-high reset
//   Start       : HALTED -> RUN pulse
//   Flush       : synchronous buffer clear (state unaffected)
//   bus         : intake and issue handshakes plus decoded head entry (slave side)
//   issue_count : number of completed output handshakes, wraps at 16 bits
module alu_issue_buffer #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned PCW   = 8
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Start,
  input  logic                Flush,
  alu_issue_buffer_if.slave   bus,
  output logic [15:0]         issue_count
);

  typedef struct packed {
    logic [3:0]     alu_op;
    logic           alu_en;
    logic           ld;
    logic           st;
    logic           br;
    logic           movi;
    logic           halt;
    logic [4:0]     operand;
    logic [PCW-1:0] pc;
  } entry_t;

  typedef enum logic [0:0] {StHalted, StRun} state_e;

  state_e      state_q, state_d;
  entry_t      mem_q [DEPTH];
  logic        head_q, tail_q;
  logic [1:0]  count_q;
  logic [15:0] issue_count_q;

  entry_t      dec;
  entry_t      head;
  logic [3:0]  opcode;
  logic        in_ready;
  logic        out_valid;
  logic        push;
  logic        pop;

  assign opcode    = bus.in_inst[8:5];
  assign out_valid = (count_q != 2'd0);
  assign push      = bus.in_valid & in_ready;
  assign pop       = out_valid & bus.out_ready;

  // Decode at intake so the buffer stores ready-to-issue control.
  always_comb begin
    dec         = '0;
    dec.operand = bus.in_inst[4:0];
    dec.pc      = bus.in_pc;
    if (opcode <= 4'd10) begin
      dec.alu_op = opcode;
      dec.alu_en = 1'b1;
    end else begin
      case (opcode)
        4'd11:   dec.ld   = 1'b1;
        4'd12:   dec.st   = 1'b1;
        4'd13:   dec.br   = 1'b1;
        4'd14:   dec.movi = 1'b1;
        default: dec.halt = 1'b1;
      endcase
    end
  end

  // FSM: state register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= StHalted;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state. Flush cannot coincide with a push, so HALT intake is never lost.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StHalted: if (Start) state_d = StRun;
      StRun:    if (push && (opcode == 4'd15)) state_d = StHalted;
      default:  state_d = StHalted;
    endcase
  end

  // FSM: outputs. in_ready is independent of out_ready; no skid through a full buffer.
  always_comb begin
    in_ready = (state_q == StRun) && (count_q != 2'(DEPTH)) && !Flush;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      head_q        <= 1'b0;
      tail_q        <= 1'b0;
      count_q       <= 2'd0;
      issue_count_q <= 16'd0;
    end else if (Flush) begin
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (push) tail_q <= ~tail_q;
      if (pop) begin
        head_q        <= ~head_q;
        issue_count_q <= issue_count_q + 16'd1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible while count_q covers them.
  always_ff @(posedge Clk) begin
    if (push) mem_q[tail_q] <= dec;
  end

  assign head = out_valid ? mem_q[head_q] : '0;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.alu_op    = head.alu_op;
  assign bus.alu_en    = head.alu_en;
  assign bus.ld        = head.ld;
  assign bus.st        = head.st;
  assign bus.br        = head.br;
  assign bus.movi      = head.movi;
  assign bus.halt      = head.halt;
  assign bus.operand   = head.operand;
  assign bus.pc_out    = head.pc;
  assign issue_count   = issue_count_q;

endmodule

// File: doc/alu_issue_buffer.md
# alu_issue_buffer

Decode-and-issue stage sitting directly upstream of the ALU. Accepts 9-bit instructions from fetch over a valid/ready handshake and decodes the 4-bit opcode into the `op_mne` ALU operation plus non-ALU control flags. It buffers up to two decoded instructions in a skid buffer and presents them to the ALU/execute stage over a second valid/ready handshake. A HALTED/RUN state machine gates intake on the `Start` and HALT instructions.

## Interface
- `DEPTH`, 2, skid-buffer entries; fixed at 2, other values unsupported
- `PCW`, 8, width of PC tag carried with each instruction
- `Clk`  in  1  clock; all state updates on rising edge
- `Reset`  in  1  synchronous, active-high reset
- `Start`  in  1  one-cycle pulse; HALTED -> RUN
- `Flush`  in  1  synchronous buffer clear (branch redirect)
- `in_valid`  in  1  fetch presents an instruction
- `in_ready`  out  1  block accepts this cycle
- `in_inst`  in  9  instruction: [8:5] opcode, [4:0] operand field
- `in_pc`  in  PCW  PC of `in_inst`
- `out_valid`  out  1  head entry valid
- `out_ready`  in  1  execute consumes the head entry
- `alu_op`  out  4  `op_mne` encoding of the head entry
- `alu_en`, `ld`, `st`, `br`, `movi`, `halt`  out  1 each  decoded class flags; exactly one is high when `out_valid`
- `operand`  out  5  `in_inst[4:0]` of the head entry
- `pc_out`  out  PCW  PC tag of the head entry
- `issue_count`  out  16  number of completed output handshakes

## Operation
- Opcode decode, done at intake and stored decoded:
  - opcodes 0–10 map to `alu_op` equal to the opcode (ADD=0, LSH, RSH, LSHZ, RSHZ, OR, XOR, AND, SUB, CLR, XORA=10), with `alu_en`=1.
  - Opcodes 11–15 set `alu_op`=0: 11 `ld`, 12 `st`, 13 `br`, 14 `movi`, 15 `halt`.
- Skid buffer: 2-entry FIFO, with head and tail and a 2-bit count.
  - Push on `in_valid & in_ready`; pop on `out_valid & out_ready`.
  - `in_ready` = (state==RUN) & (count<2) & ~`Flush`.
  - `out_valid` = (count>0).
  - When empty, all decoded outputs, `operand` and `pc_out` drive 0.
- Simultaneous push and pop at count 1: count stays 1 and the pushed entry becomes head next cycle. Push is impossible at count 2.
- States:
  - HALTED: reset state. `Start` -> RUN. Other inputs are ignored except `Flush` and the output side, which continues draining.
  - RUN: accepting a HALT instruction (opcode 15) -> HALTED on the same edge. The HALT entry is still buffered and issued with `halt`=1. `Start` in RUN is ignored.
- `Flush`: count -> 0 and pointers -> 0; the state is unchanged. Flush dominates any push or pop in the same cycle, and a pop in that cycle does not increment `issue_count`.
- `issue_count` increments on each output handshake. It wraps 0xFFFF -> 0 and is cleared only by `Reset`.
- `Reset`: state HALTED, count 0, `issue_count` 0. `Reset` overrides `Start`, `Flush` and both handshakes.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `alu_op`=0, all flags 0, `operand`=0, `pc_out`=0, `issue_count`=0.
- Latency: an instruction accepted at edge N is presented with `out_valid`=1 after edge N (visible in cycle N+1). There is no combinational path from `in_*` to `out_*`.
- `in_ready` depends only on registered state and `Flush`; it does not depend on `out_ready`.
- Intake after `Start`: `Start` sampled at edge N makes `in_ready` high in cycle N+1 (given count<2).
- HALT acceptance: if HALT is accepted at edge N, `in_ready`=0 from cycle N+1 onward.
- Output data is held stable while `out_valid & ~out_ready`.
- Throughput: one instruction per cycle when `out_ready` is held high.

## Test plan
- Reset, then `Start`, then push ADD (0x000), SUB (opcode 8, operand 5), XORA (opcode 10), with `out_ready`=1. Required: three issues in order with `alu_op` 0/8/10 and `alu_en`=1, `operand` 0/5/x, and `issue_count`=3.
- `out_ready`=0 with three back-to-back pushes. Required: `in_ready` drops after the 2nd push, and head data is held stable. On raising `out_ready`, the two entries issue in order and the 3rd is accepted when `in_ready` returns.
- Decode of opcodes 11–15. Required: exactly one of `ld`/`st`/`br`/`movi`/`halt` is high for each, with `alu_op`=0 and `alu_en`=0.
- HALT at count 0 followed by a valid LSH. Required: LSH is not accepted and HALT issues with `halt`=1. `Start` then re-enables intake and LSH issues with `alu_op`=1.
- `Flush` with 2 entries while `in_valid`=1 and `out_ready`=1. Required: next cycle `out_valid`=0, count is 0, `issue_count` is unchanged, and the new instruction is not accepted.
- Preload `issue_count` to 0xFFFF through 65535 handshakes, then one more. Required: `issue_count` wraps to 0.
